// File: rtl/cpu_clock_controller.sv
// Purpose: CPU sequencer producing a one-clk cpu_ce in free-run (clk/RATIO), halted and single-step modes.
// Latency: switch/button edge -> 2 clk sync + DEBOUNCE clk qualify -> 1 clk state change; first RUN pulse RATIO clk after entry.
// Backpressure: none; cpu_ce is a fire-and-forget enable, halt_in from the CPU stops the pulse train until the switch is re-armed.
module cpu_clock_controller #(
    parameter int RATIO    = 100,
    parameter int DEBOUNCE = 16
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        halt_in,
    output logic        cpu_ce,
    output logic        running,
    output logic [15:0] tick_count
);

    localparam logic [15:0] DIV_LAST = 16'(RATIO - 1);
    localparam logic [15:0] DB_LAST  = 16'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_div;
    logic        r_ce;
    logic        r_running;
    logic [15:0] r_tick_count;

    logic        r_run_s1;
    logic        r_run_s2;
    logic        r_step_s1;
    logic        r_step_s2;

    logic [15:0] r_run_cnt;
    logic        r_run_db;
    logic [15:0] r_step_cnt;
    logic        r_step_db;
    logic        r_step_db_d;

    logic [1:0]  r_prime;
    logic        r_step_armed;

    logic        w_step_evt;

    // Two-flop synchronizers for the asynchronous board inputs
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_run_s1  <= 1'b0;
            r_run_s2  <= 1'b0;
            r_step_s1 <= 1'b0;
            r_step_s2 <= 1'b0;
        end else begin
            r_run_s1  <= run_sw;
            r_run_s2  <= r_run_s1;
            r_step_s1 <= step_btn;
            r_step_s2 <= r_step_s1;
        end
    end

    // Run switch debounce: accept a change only after DEBOUNCE consecutive differing cycles
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_run_cnt <= '0;
            r_run_db  <= 1'b0;
        end else if (r_run_s2 == r_run_db) begin
            r_run_cnt <= '0;
        end else if (r_run_cnt == DB_LAST) begin
            r_run_db  <= r_run_s2;
            r_run_cnt <= '0;
        end else begin
            r_run_cnt <= r_run_cnt + 16'd1;
        end
    end

    // Step button debounce, same qualification as the run switch
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_step_cnt <= '0;
            r_step_db  <= 1'b0;
        end else if (r_step_s2 == r_step_db) begin
            r_step_cnt <= '0;
        end else if (r_step_cnt == DB_LAST) begin
            r_step_db  <= r_step_s2;
            r_step_cnt <= '0;
        end else begin
            r_step_cnt <= r_step_cnt + 16'd1;
        end
    end

    // Step edge history and arming: the button must be seen released once the synchronizer
    // holds real samples, so a button held through reset never yields a step
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_step_db_d  <= 1'b0;
            r_prime      <= 2'b00;
            r_step_armed <= 1'b0;
        end else begin
            r_step_db_d <= r_step_db;
            r_prime     <= {r_prime[0], 1'b1};
            if (r_prime[1] && !r_step_s2) begin
                r_step_armed <= 1'b1;
            end
        end
    end

    assign w_step_evt = r_step_db & ~r_step_db_d & r_step_armed;

    // Mode FSM with divider; cpu_ce and running are registered alongside the state
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state   <= ST_HALT;
            r_div     <= '0;
            r_ce      <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_ce <= 1'b0;
            case (r_state)
                ST_HALT: begin
                    if (w_step_evt) begin
                        r_ce <= 1'b1;
                    end else if (r_run_db) begin
                        r_state   <= ST_RUN;
                        r_div     <= '0;
                        r_running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // leaving RUN beats a pulse due in the same cycle; switch-off beats halt_in
                    if (!r_run_db) begin
                        r_state   <= ST_HALT;
                        r_running <= 1'b0;
                    end else if (halt_in) begin
                        r_state   <= ST_STOP;
                        r_running <= 1'b0;
                    end else if (r_div == DIV_LAST) begin
                        r_div <= '0;
                        r_ce  <= 1'b1;
                    end else begin
                        r_div <= r_div + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (!r_run_db) begin
                        r_state <= ST_HALT;
                    end
                end
                default: begin
                    r_state   <= ST_HALT;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    // Count issued pulses, wrapping at 16 bits
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_tick_count <= '0;
        end else if (r_ce) begin
            r_tick_count <= r_tick_count + 16'd1;
        end
    end

    assign cpu_ce     = r_ce;
    assign running    = r_running;
    assign tick_count = r_tick_count;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Purpose: scoreboard bench for cpu_clock_controller with RATIO=4, DEBOUNCE=3.
// Latency: expectations are keyed to absolute clk cycle numbers.
// Backpressure: none; the monitor consumes every cpu_ce pulse and every scheduled probe.
module tb_cpu_clock_controller;

    localparam logic [1:0] S_HALT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;

    logic        clk;
    logic        n_reset;
    logic        run_sw;
    logic        step_btn;
    logic        halt_in;
    logic        cpu_ce;
    logic        running;
    logic [15:0] tick_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic tb_done = 1'b0;

    typedef struct {
        int          cyc;
        logic [15:0] tick;
    } pulse_t;

    typedef struct {
        int          cyc;
        logic        run;
        logic [15:0] tick;
        logic [1:0]  st;
        string       name;
    } probe_t;

    pulse_t pulse_q[$];
    probe_t probe_q[$];

    cpu_clock_controller #(
        .RATIO    (4),
        .DEBOUNCE (3)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .run_sw     (run_sw),
        .step_btn   (step_btn),
        .halt_in    (halt_in),
        .cpu_ce     (cpu_ce),
        .running    (running),
        .tick_count (tick_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void exp_pulse(int c, logic [15:0] t);
        pulse_t p;
        p.cyc  = c;
        p.tick = t;
        pulse_q.push_back(p);
    endfunction

    function automatic void exp_probe(int c, logic r, logic [15:0] t, logic [1:0] s, string n);
        probe_t p;
        p.cyc  = c;
        p.run  = r;
        p.tick = t;
        p.st   = s;
        p.name = n;
        probe_q.push_back(p);
    endfunction

    task automatic at(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: sample on the falling edge, match pulses and probes against the scoreboard
    logic [1:0] st_now;
    always @(negedge clk) begin
        pulse_t e;
        probe_t p;
        st_now = dut.r_state;
        while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
            e = pulse_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_pulse: none at cyc %0d, required pulse with tick=%h", e.cyc, e.tick);
        end
        if (cpu_ce === 1'b1) begin
            checks++;
            if (pulse_q.size() == 0 || pulse_q[0].cyc != cyc) begin
                failures++;
                $display("FAIL unexpected_pulse: cpu_ce=1 at cyc %0d tick=%h, required no pulse", cyc, tick_count);
            end else begin
                e = pulse_q.pop_front();
                if (tick_count !== e.tick) begin
                    failures++;
                    $display("FAIL pulse_tick: cyc %0d tick=%h, required %h", cyc, tick_count, e.tick);
                end
            end
        end
        while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
            p = probe_q.pop_front();
            checks++;
            if (p.cyc != cyc || cpu_ce !== 1'b0 || running !== p.run ||
                tick_count !== p.tick || st_now !== p.st) begin
                failures++;
                $display("FAIL %s: cyc %0d ce=%b running=%b tick=%h state=%0d, required cyc %0d ce=0 running=%b tick=%h state=%0d",
                         p.name, cyc, cpu_ce, running, tick_count, st_now, p.cyc, p.run, p.tick, p.st);
            end
        end
        if (tb_done) begin
            while (pulse_q.size() > 0) begin
                e = pulse_q.pop_front();
                checks++;
                failures++;
                $display("FAIL pending_pulse: cyc %0d never checked, required tick=%h", e.cyc, e.tick);
            end
            while (probe_q.size() > 0) begin
                p = probe_q.pop_front();
                checks++;
                failures++;
                $display("FAIL pending_%s: cyc %0d never checked", p.name, p.cyc);
            end
        end
    end

    // Directed stimulus; every expectation is hand-derived from the cycle the input changes
    initial begin
        int t, e, g, h, u, s1, s2, r, v, w;
        n_reset  = 1'b0;
        run_sw   = 1'b0;
        step_btn = 1'b0;
        halt_in  = 1'b0;

        at(2);
        exp_probe(2, 1'b0, 16'h0000, S_HALT, "reset_state");
        at(3);
        n_reset = 1'b1;
        at(8);

        // Free run: RUN 2+3+1 clk after switch, pulses every 4 clk from entry+4
        t = cyc;
        run_sw = 1'b1;
        exp_probe(t + 5, 1'b0, 16'd0, S_HALT, "pre_run");
        exp_probe(t + 6, 1'b1, 16'd0, S_RUN, "run_entry");
        for (int k = 0; k < 10; k++) exp_pulse(t + 10 + 4 * k, 16'(k));
        exp_probe(t + 47, 1'b1, 16'd10, S_RUN, "tick_ten");

        // halt_in for one clk -> STOP, no further pulses, step ignored
        at(t + 47);
        halt_in = 1'b1;
        at(t + 48);
        halt_in = 1'b0;
        exp_probe(t + 48, 1'b0, 16'd10, S_STOP, "stop_entry");
        exp_probe(t + 50, 1'b0, 16'd10, S_STOP, "stop_no_pulse");
        at(t + 52);
        step_btn = 1'b1;
        at(t + 62);
        step_btn = 1'b0;
        exp_probe(t + 70, 1'b0, 16'd10, S_STOP, "stop_step_ignored");

        // Switch off -> HALT, switch on -> RUN with first pulse 4 clk after entry
        at(t + 72);
        run_sw = 1'b0;
        exp_probe(t + 77, 1'b0, 16'd10, S_STOP, "stop_hold");
        exp_probe(t + 78, 1'b0, 16'd10, S_HALT, "stop_to_halt");
        at(t + 82);
        e = cyc;
        run_sw = 1'b1;
        exp_probe(e + 6, 1'b1, 16'd10, S_RUN, "rerun_entry");
        exp_pulse(e + 10, 16'd10);

        // Switch-off and halt_in both seen on the cycle a pulse is due: HALT, no pulse
        at(e + 8);
        run_sw = 1'b0;
        at(e + 13);
        halt_in = 1'b1;
        at(e + 14);
        halt_in = 1'b0;
        exp_probe(e + 14, 1'b0, 16'd11, S_HALT, "exit_priority");
        exp_probe(e + 16, 1'b0, 16'd11, S_HALT, "exit_no_pulse");

        // Single step: long press gives one pulse, release gives nothing, 2-clk glitch gives nothing
        at(e + 20);
        g = cyc;
        step_btn = 1'b1;
        exp_pulse(g + 6, 16'd11);
        exp_probe(g + 7, 1'b0, 16'd12, S_HALT, "step_tick");
        at(g + 20);
        step_btn = 1'b0;
        at(g + 30);
        h = cyc;
        step_btn = 1'b1;
        at(h + 2);
        step_btn = 1'b0;
        exp_probe(h + 12, 1'b0, 16'd12, S_HALT, "glitch_rejected");

        // Counter wrap from a preloaded FFFE via two steps
        at(h + 14);
        u = cyc;
        force dut.r_tick_count = 16'hFFFE;
        at(u + 1);
        release dut.r_tick_count;
        exp_probe(u + 2, 1'b0, 16'hFFFE, S_HALT, "preload");
        at(u + 4);
        s1 = cyc;
        step_btn = 1'b1;
        exp_pulse(s1 + 6, 16'hFFFE);
        exp_probe(s1 + 7, 1'b0, 16'hFFFF, S_HALT, "wrap_ffff");
        at(s1 + 10);
        step_btn = 1'b0;
        at(s1 + 20);
        s2 = cyc;
        step_btn = 1'b1;
        exp_pulse(s2 + 6, 16'hFFFF);
        exp_probe(s2 + 7, 1'b0, 16'h0000, S_HALT, "wrap_zero");
        at(s2 + 10);
        step_btn = 1'b0;

        // Reset in RUN with divider=3: pulse dropped, outputs clear, RUN again 6 clk after release
        at(s2 + 20);
        r = cyc;
        run_sw = 1'b1;
        exp_pulse(r + 10, 16'd0);
        at(r + 13);
        n_reset  = 1'b0;
        step_btn = 1'b1;
        exp_probe(r + 13, 1'b0, 16'd0, S_HALT, "reset_midrun");
        at(r + 15);
        n_reset = 1'b1;
        exp_probe(r + 20, 1'b0, 16'd0, S_HALT, "reset_pre_rerun");
        exp_probe(r + 21, 1'b1, 16'd0, S_RUN, "reset_rerun");
        exp_pulse(r + 25, 16'd0);
        exp_pulse(r + 29, 16'd1);
        exp_pulse(r + 33, 16'd2);
        at(r + 30);
        run_sw = 1'b0;
        at(r + 31);
        step_btn = 1'b0;
        exp_probe(r + 37, 1'b0, 16'd3, S_HALT, "off_after_reset");

        // Button held through reset in HALT yields no step; a fresh press afterwards does
        at(r + 40);
        v = cyc;
        step_btn = 1'b1;
        at(v + 1);
        n_reset = 1'b0;
        at(v + 3);
        n_reset = 1'b1;
        exp_probe(v + 15, 1'b0, 16'd0, S_HALT, "held_thru_reset");
        at(v + 16);
        step_btn = 1'b0;
        at(v + 26);
        w = cyc;
        step_btn = 1'b1;
        exp_pulse(w + 6, 16'd0);
        exp_probe(w + 7, 1'b0, 16'd1, S_HALT, "step_after_rearm");
        at(w + 10);
        step_btn = 1'b0;

        at(w + 20);
        tb_done = 1'b1;
        at(w + 23);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
